// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel strobe, h/v sync, active window and coordinates.
// Define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int CLK_DIV  = 2,
    parameter int CW       = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    output logic          pix_tick,
    output logic          hsync,
    output logic          vsync,
    output logic          active,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic          busy
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]   frame_cnt
`endif
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_FIRST = H_ACTIVE + H_FP;
    localparam int HS_LAST  = HS_FIRST + H_SYNC - 1;
    localparam int VS_FIRST = V_ACTIVE + V_FP;
    localparam int VS_LAST  = VS_FIRST + V_SYNC - 1;
    localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] X_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] Y_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] X_VIS    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] Y_VIS    = CW'(V_ACTIVE);
    localparam logic          HS_ON    = 1'(H_POL);
    localparam logic          VS_ON    = 1'(V_POL);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t        r_state;
    logic [DW-1:0] r_div;

    state_t        w_state_nx;
    logic [DW-1:0] w_div_nx;
    logic [CW-1:0] w_x_nx;
    logic [CW-1:0] w_y_nx;
    logic          w_busy_nx;
    logic          w_tick;
    logic          w_eol;
    logic          w_eof;
    logic          w_hs_win;
    logic          w_vs_win;

    // Next-state values are computed first so every registered output is
    // derived from the same (x, y, div) it will appear alongside.
    always_comb begin
        w_state_nx = r_state;
        w_div_nx   = r_div;
        w_x_nx     = x;
        w_y_nx     = y;
        w_tick     = (r_state != S_IDLE) && (r_div == DIV_LAST);
        w_eol      = (x == X_LAST);
        w_eof      = w_tick && w_eol && (y == Y_LAST);

        case (r_state)
            S_IDLE: begin
                w_div_nx = '0;
                w_x_nx   = '0;
                w_y_nx   = '0;
                if (run) begin
                    w_state_nx = S_RUN;
                end
            end
            default: begin
                w_div_nx = w_tick ? '0 : r_div + 1'b1;
                if (w_tick) begin
                    if (w_eol) begin
                        w_x_nx = '0;
                        w_y_nx = (y == Y_LAST) ? '0 : y + 1'b1;
                    end else begin
                        w_x_nx = x + 1'b1;
                    end
                end
                if (w_eof && !run) begin
                    w_state_nx = S_IDLE;
                    w_div_nx   = '0;
                    w_x_nx     = '0;
                    w_y_nx     = '0;
                end else begin
                    w_state_nx = run ? S_RUN : S_DRAIN;
                end
            end
        endcase

        w_busy_nx = (w_state_nx != S_IDLE);
        w_hs_win  = (int'(w_x_nx) >= HS_FIRST) && (int'(w_x_nx) <= HS_LAST);
        w_vs_win  = (int'(w_y_nx) >= VS_FIRST) && (int'(w_y_nx) <= VS_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_div       <= '0;
            x           <= '0;
            y           <= '0;
            busy        <= 1'b0;
            pix_tick    <= 1'b0;
            active      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            hsync       <= ~HS_ON;
            vsync       <= ~VS_ON;
        end else begin
            r_state     <= w_state_nx;
            r_div       <= w_div_nx;
            x           <= w_x_nx;
            y           <= w_y_nx;
            busy        <= w_busy_nx;
            pix_tick    <= w_busy_nx && (w_div_nx == DIV_LAST);
            active      <= w_busy_nx && (w_x_nx < X_VIS) && (w_y_nx < Y_VIS);
            line_start  <= w_busy_nx && (w_div_nx == '0) && (w_x_nx == '0);
            frame_start <= w_busy_nx && (w_div_nx == '0) && (w_x_nx == '0) && (w_y_nx == '0);
            hsync       <= (w_busy_nx && w_hs_win) ? HS_ON : ~HS_ON;
            vsync       <= (w_busy_nx && w_vs_win) ? VS_ON : ~VS_ON;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_cnt <= '0;
        end else if (frame_start) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: small 8x6 raster, CLK_DIV=2 active-low (A)
// and CLK_DIV=1 active-high (B); expected events are queued, monitors pop and compare.
module tb_vga_timing_gen;

    localparam int HT = 8;
    localparam int VT = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_a, run_a, reset_b, run_b;
    logic       pix_tick_a, hsync_a, vsync_a, active_a, line_start_a, frame_start_a, busy_a;
    logic       pix_tick_b, hsync_b, vsync_b, active_b, line_start_b, frame_start_b, busy_b;
    logic [3:0] x_a, y_a, x_b, y_b;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_a, frame_cnt_b;
`endif

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(0), .V_POL(0), .CLK_DIV(2), .CW(4)
    ) dut_a (
        .clk(clk), .reset(reset_a), .run(run_a),
        .pix_tick(pix_tick_a), .hsync(hsync_a), .vsync(vsync_a), .active(active_a),
        .x(x_a), .y(y_a), .line_start(line_start_a), .frame_start(frame_start_a),
        .busy(busy_a)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(frame_cnt_a)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1), .V_POL(1), .CLK_DIV(1), .CW(4)
    ) dut_b (
        .clk(clk), .reset(reset_b), .run(run_b),
        .pix_tick(pix_tick_b), .hsync(hsync_b), .vsync(vsync_b), .active(active_b),
        .x(x_b), .y(y_b), .line_start(line_start_b), .frame_start(frame_start_b),
        .busy(busy_b)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(frame_cnt_b)
`endif
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int cyc;
        int x;
        int y;
        bit hs;
        bit vs;
        bit act;
        bit ls;
        bit fs;
    } pix_t;

    pix_t pixq[2][$];
    int   fsq[2][$];
    int   idq[2][$];
    logic [1:0] bprev = 2'b00;

    // Sync windows of the 8x6 raster: x in {5,6}, y == 4.
    bit hs_win[8] = '{0, 0, 0, 0, 0, 1, 1, 0};
    bit vs_win[6] = '{0, 0, 0, 0, 1, 0};

    task automatic cmp(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got an event, expected none (cyc %0d)", name, cyc);
    endtask

    // Queue the per-pixel expectations for pixels 0..p_last of a frame whose
    // first cycle is f; the sample point is the pix_tick cycle of each pixel.
    task automatic push_frame(input int d, input int f, input int div, input bit pol,
                              input int p_last);
        for (int p = 0; p <= p_last; p++) begin
            pix_t e;
            e.x   = p % HT;
            e.y   = p / HT;
            e.cyc = f + div * p + div - 1;
            e.hs  = pol ? hs_win[e.x] : !hs_win[e.x];
            e.vs  = pol ? vs_win[e.y] : !vs_win[e.y];
            e.act = (e.x < 4) && (e.y < 3);
            e.ls  = (div == 1) && (e.x == 0);
            e.fs  = (div == 1) && (p == 0);
            pixq[d].push_back(e);
        end
        fsq[d].push_back(f);
    endtask

    task automatic mon(input int d, input string n, input logic tick, input logic fs,
                       input logic ls, input logic act, input logic bsy, input logic hs,
                       input logic vs, input int xx, input int yy, input logic prevb,
                       input logic hs_off, input logic vs_off);
        pix_t e;
        int   c;
        if (tick) begin
            if (pixq[d].size() == 0) flag({n, " pix_tick"});
            else begin
                e = pixq[d].pop_front();
                cmp({n, " tick cycle"}, cyc, e.cyc);
                cmp({n, " x"}, xx, e.x);
                cmp({n, " y"}, yy, e.y);
                cmp({n, " hsync"}, int'(hs), int'(e.hs));
                cmp({n, " vsync"}, int'(vs), int'(e.vs));
                cmp({n, " active"}, int'(act), int'(e.act));
                cmp({n, " line_start"}, int'(ls), int'(e.ls));
                cmp({n, " frame_start"}, int'(fs), int'(e.fs));
            end
        end
        if (fs) begin
            if (fsq[d].size() == 0) flag({n, " frame_start"});
            else begin
                c = fsq[d].pop_front();
                cmp({n, " frame_start cycle"}, cyc, c);
                cmp({n, " fs x"}, xx, 0);
                cmp({n, " fs y"}, yy, 0);
                cmp({n, " fs line_start"}, int'(ls), 1);
                cmp({n, " fs active"}, int'(act), 1);
                cmp({n, " fs busy"}, int'(bsy), 1);
            end
        end
        if (prevb && !bsy) begin
            if (idq[d].size() == 0) flag({n, " busy fall"});
            else begin
                c = idq[d].pop_front();
                cmp({n, " idle cycle"}, cyc, c);
                cmp({n, " idle x"}, xx, 0);
                cmp({n, " idle y"}, yy, 0);
                cmp({n, " idle hsync"}, int'(hs), int'(hs_off));
                cmp({n, " idle vsync"}, int'(vs), int'(vs_off));
                cmp({n, " idle active"}, int'(act), 0);
                cmp({n, " idle pix_tick"}, int'(tick), 0);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, "A", pix_tick_a, frame_start_a, line_start_a, active_a, busy_a, hsync_a,
            vsync_a, int'(x_a), int'(y_a), bprev[0], 1'b1, 1'b1);
        mon(1, "B", pix_tick_b, frame_start_b, line_start_b, active_b, busy_b, hsync_b,
            vsync_b, int'(x_b), int'(y_b), bprev[1], 1'b0, 1'b0);
        bprev = {busy_b, busy_a};
    end

    task automatic at_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_drained(input int d, input string n);
        cmp({n, " pixel queue left"}, pixq[d].size(), 0);
        cmp({n, " frame_start queue left"}, fsq[d].size(), 0);
        cmp({n, " idle queue left"}, idq[d].size(), 0);
    endtask

    int s0, f1, f2, f4, f5, sb;

    initial begin
        reset_a = 1'b1; run_a = 1'b0;
        reset_b = 1'b1; run_b = 1'b0;
        at_cyc(3);
        @(negedge clk);
        cmp("A reset busy", int'(busy_a), 0);
        cmp("A reset hsync", int'(hsync_a), 1);
        cmp("A reset vsync", int'(vsync_a), 1);
        cmp("A reset x", int'(x_a), 0);
        cmp("A reset y", int'(y_a), 0);
        cmp("A reset pix_tick", int'(pix_tick_a), 0);
        cmp("A reset active", int'(active_a), 0);
        cmp("A reset frame_start", int'(frame_start_a), 0);
        cmp("B reset hsync", int'(hsync_b), 0);
        cmp("B reset vsync", int'(vsync_b), 0);
        cmp("B reset busy", int'(busy_b), 0);

        // Start: frame (0,0) shows on the edge that samples run high.
        at_cyc(5);
        s0 = 6; f1 = s0 + 96; f2 = s0 + 192;
        push_frame(0, s0, 2, 0, 47);
        push_frame(0, f1, 2, 0, 47);
        push_frame(0, f2, 2, 0, 47);
        idq[0].push_back(f2 + 96);
        reset_a = 1'b0; run_a = 1'b1;

        // Drop and reassert within the drain: no restart, period stays 96.
        at_cyc(f1 + 20); run_a = 1'b0;
        at_cyc(f1 + 40); run_a = 1'b1;
`ifdef VGA_TIMING_FRAME_CNT_EN
        at_cyc(f2 + 5);
        cmp("A frame_cnt after 3 frames", int'(frame_cnt_a), 3);
`endif
        // Drop at pixel (2,1): runs to (7,5), idle on the next edge.
        at_cyc(f2 + 20); run_a = 1'b0;
        at_cyc(f2 + 110);
        check_drained(0, "A stop");

        // Reset during the sync region at (5,4), run kept high.
        run_a = 1'b1;
        f4 = f2 + 111;
        push_frame(0, f4, 2, 0, 36);
        idq[0].push_back(f4 + 75);
        at_cyc(f4 + 74); reset_a = 1'b1;
        at_cyc(f4 + 75); reset_a = 1'b0;
        f5 = f4 + 76;
        push_frame(0, f5, 2, 0, 47);
        idq[0].push_back(f5 + 96);
        at_cyc(f5 + 1); run_a = 1'b0;
        at_cyc(f5 + 110);
        check_drained(0, "A reset");

        // CLK_DIV=1, active-high syncs.
        sb = f5 + 111;
        push_frame(1, sb, 1, 1, 47);
        push_frame(1, sb + 48, 1, 1, 47);
        idq[1].push_back(sb + 96);
        at_cyc(sb - 1); reset_b = 1'b0; run_b = 1'b1;
        at_cyc(sb + 58); run_b = 1'b0;
        at_cyc(sb + 110);
        check_drained(1, "B");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
